fwd_hazard_unit: RTL

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects, load-use / multiplier hazard detection and a
// saturating stall counter for a five-stage pipeline with a multi-cycle multiplier.
module fwd_hazard_unit #(
  parameter int ADDR_W  = 5,
  parameter int NSRC    = 2,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [NSRC*ADDR_W-1:0] id_src,
  input  logic [NSRC-1:0]        id_src_used,
  input  logic [ADDR_W-1:0]      id_rd,
  input  logic                   id_regWrite,
  input  logic                   id_is_mul,
  input  logic [ADDR_W-1:0]      rd_IDEX,
  input  logic                   memRead_IDEX,
  input  logic [NSRC*ADDR_W-1:0] ex_src,
  input  logic [ADDR_W-1:0]      rd_EXMEM,
  input  logic                   regWrite_EXMEM,
  input  logic [ADDR_W-1:0]      rd_MEMWB,
  input  logic                   regWrite_MEMWB,
  input  logic                   flush,
  output logic [2*NSRC-1:0]      forward,
  output logic                   stall,
  output logic                   mul_busy,
  output logic                   mul_done,
  output logic [ADDR_W-1:0]      mul_rd,
  output logic [CNT_W-1:0]       stall_count
);

  localparam int CNT_BITS = $clog2(MUL_LAT);

  typedef enum logic {IDLE, BUSY} mulState_t;

  mulState_t           state, stateNext;
  logic [CNT_BITS-1:0] cnt, cntNext;
  logic [ADDR_W-1:0]   mulRdNext;
  logic                cntZero;
  logic                loadUse, rawHaz, wawHaz, structHaz, mulAccept;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    forward = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (regWrite_EXMEM && rd_EXMEM != '0 && rd_EXMEM == ex_src[i*ADDR_W +: ADDR_W])
        forward[2*i +: 2] = 2'b10;
      else if (regWrite_MEMWB && rd_MEMWB != '0 && rd_MEMWB == ex_src[i*ADDR_W +: ADDR_W])
        forward[2*i +: 2] = 2'b01;
    end
  end

  always_comb begin
    loadUse = 1'b0;
    rawHaz  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (id_src_used[i]) begin
        if (memRead_IDEX && rd_IDEX != '0 && id_src[i*ADDR_W +: ADDR_W] == rd_IDEX)
          loadUse = 1'b1;
        if (mul_busy && mul_rd != '0 && id_src[i*ADDR_W +: ADDR_W] == mul_rd)
          rawHaz = 1'b1;
      end
    end
  end

  // The result lands at the end of the mul_done cycle, so a reader still waits
  // through that cycle, while a new multiply may issue into it (cnt == 0).
  assign cntZero   = (cnt == '0);
  assign wawHaz    = mul_busy && id_regWrite && id_rd != '0 && id_rd == mul_rd;
  assign structHaz = mul_busy && id_is_mul && !cntZero;
  assign stall     = id_valid && !flush && (loadUse || rawHaz || wawHaz || structHaz);
  assign mulAccept = id_valid && id_is_mul && !stall && !flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mul_rd <= '0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      mul_rd <= mulRdNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    mulRdNext = mul_rd;
    case (state)
      IDLE: begin
        if (mulAccept) begin
          stateNext = BUSY;
          cntNext   = CNT_BITS'(MUL_LAT - 1);
          mulRdNext = id_rd;
        end
      end
      BUSY: begin
        if (!cntZero) begin
          cntNext = cnt - 1'b1;
        end else if (mulAccept) begin
          cntNext   = CNT_BITS'(MUL_LAT - 1);
          mulRdNext = id_rd;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    mul_busy = (state == BUSY);
    mul_done = (state == BUSY) && cntZero;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if (stall && stall_count != '1)
      stall_count <= stall_count + 1'b1;
  end

endmodule
